sram_access_seq: RTL and testbench

- Multi-cycle SRAM bus sequencer between the SLC-3 memory-side logic (MAR/MDR, Mem2IO) and the external 1Mx16 asynchronous SRAM.
- Accepts single-word read/write requests with a request/busy/done handshake and drives active-low CE/UB/LB/OE/WE.
- Adds programmable wait states and owns the tristate data enable.
- Replaces the fixed "hold R for N states" timing in ISDU memory states with an explicit completion signal.

---
 rtl/sram_access_seq.sv | 168 ++++++++++++++++
 tb/tb_sram_access_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_seq.sv
// rtl/sram_access_seq.sv - multi-cycle single-word sequencer for a 1Mx16 asynchronous SRAM
//
// Purpose: accepts one read or write request at a time from the memory-side
// logic and runs it on the SRAM bus as IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE.
// It drives the active-low strobes, owns the tristate data enable and reports
// completion with a one-cycle Done pulse.
//
// Optional build macro: SRAM_SEQ_BYTE_EN. When it is defined, Byte_Sel is captured
// with the request and drives UB/LB during ACCESS. When it is not defined,
// Byte_Sel is ignored and both bytes are always enabled.
//
// Parameters:
//   WAIT_CYCLES  wait cycles per access, legal range 1..15; ACCESS lasts WAIT_CYCLES+1 cycles
//   CNT_W        wait counter width; must be wide enough to hold WAIT_CYCLES
//
// Ports:
//   Clk, Reset            clock; asynchronous active-low reset
//   Req_Rd, Req_Wr        level requests, sampled only in IDLE (read wins if both are high)
//   Addr, Wr_Data         captured when a request is accepted
//   Byte_Sel              [1]=upper byte, [0]=lower byte (SRAM_SEQ_BYTE_EN only)
//   Busy, Done            Busy=state!=IDLE; Done is a one-cycle completion pulse
//   Rd_Data               result of the most recent completed read
//   SRAM_ADDR, SRAM_Dout  registered address and write data
//   SRAM_Din              data read back from the tristate buffer
//   Data_OE               tristate output enable, active high
//   CE, UB, LB, OE, WE    SRAM strobes, active low

module sram_access_seq #(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_Rd,
    input  logic        Req_Wr,
    input  logic [19:0] Addr,
    input  logic [15:0] Wr_Data,
    input  logic [1:0]  Byte_Sel,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Rd_Data,
    output logic [19:0] SRAM_ADDR,
    output logic [15:0] SRAM_Dout,
    input  logic [15:0] SRAM_Din,
    output logic        Data_OE,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             op_rd;
    logic             cnt_last;
    logic             accept;
    logic             ub_act;
    logic             lb_act;

    assign cnt_last = (cnt == CNT_LAST);
    assign accept   = (state == S_IDLE) && (Req_Rd || Req_Wr);

`ifdef SRAM_SEQ_BYTE_EN
    logic [1:0] sel_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sel_q <= 2'b00;
        end else if (accept) begin
            sel_q <= Byte_Sel;
        end
    end

    // Byte_Sel=00 leaves both byte lanes disabled: a timed no-op access.
    assign ub_act = ~sel_q[1];
    assign lb_act = ~sel_q[0];
`else
    logic unused_byte_sel;

    assign unused_byte_sel = ^Byte_Sel;
    assign ub_act          = 1'b0;
    assign lb_act          = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        CE        = 1'b1;
        OE        = 1'b1;
        WE        = 1'b1;
        UB        = 1'b1;
        LB        = 1'b1;
        Data_OE   = 1'b0;
        case (state)
            S_IDLE: begin
                if (Req_Rd || Req_Wr) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                Busy = 1'b1;
                CE   = 1'b0;
                UB   = ub_act;
                LB   = lb_act;
                if (op_rd) begin
                    OE = 1'b0;
                end else begin
                    // WE rises for the final cycle so data is held past the write edge.
                    Data_OE = 1'b1;
                    WE      = cnt_last;
                end
                if (cnt_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt       <= '0;
            op_rd     <= 1'b0;
            SRAM_ADDR <= '0;
            SRAM_Dout <= '0;
            Rd_Data   <= '0;
        end else if (accept) begin
            cnt       <= '0;
            op_rd     <= Req_Rd;
            SRAM_ADDR <= Addr;
            SRAM_Dout <= Wr_Data;
        end else if (state == S_ACCESS) begin
            // The counter stops at CNT_LAST, so it never wraps.
            if (!cnt_last) begin
                cnt <= cnt + 1'b1;
            end else if (op_rd) begin
                Rd_Data <= SRAM_Din;
            end
        end
    end

endmodule

// File: tb/tb_sram_access_seq.sv
// tb/tb_sram_access_seq.sv - scoreboard bench for sram_access_seq with a behavioural SRAM

module tb_sram_access_seq;

    localparam int W = 2;

`ifdef SRAM_SEQ_BYTE_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Req_Rd = 1'b0;
    logic        Req_Wr = 1'b0;
    logic [19:0] Addr = '0;
    logic [15:0] Wr_Data = '0;
    logic [1:0]  Byte_Sel = '0;
    logic        Busy, Done, Data_OE, CE, UB, LB, OE, WE;
    logic [15:0] Rd_Data, SRAM_Dout, SRAM_Din;
    logic [19:0] SRAM_ADDR;

    sram_access_seq #(.WAIT_CYCLES(W), .CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .Req_Rd(Req_Rd), .Req_Wr(Req_Wr),
        .Addr(Addr), .Wr_Data(Wr_Data), .Byte_Sel(Byte_Sel),
        .Busy(Busy), .Done(Done), .Rd_Data(Rd_Data),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_Dout(SRAM_Dout), .SRAM_Din(SRAM_Din),
        .Data_OE(Data_OE), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] init_word(input int i);
        if (i == 8'h12) return 16'hBEEF;
        if (i == 8'h78) return 16'h55CC;
        return 16'(i * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] sel);
        if (!BE) return nw;
        return {sel[1] ? nw[15:8] : old[15:8], sel[0] ? nw[7:0] : old[7:0]};
    endfunction

    // Expected {UB,LB} during ACCESS.
    function automatic logic [1:0] strobe_ul(input logic [1:0] sel);
        return BE ? ~sel : 2'b00;
    endfunction

    // External SRAM: 256 words, aliased on the low address byte; writes on the WE rising edge.
    logic [15:0] mem [0:255];
    always_comb SRAM_Din = (!CE && !OE) ? mem[SRAM_ADDR[7:0]] : 16'hDEAD;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        forever begin
            @(posedge WE);
            if (!CE) begin
                if (!UB) mem[SRAM_ADDR[7:0]][15:8] = SRAM_Dout[15:8];
                if (!LB) mem[SRAM_ADDR[7:0]][7:0]  = SRAM_Dout[7:0];
            end
        end
    end

    // Reference model: word store plus the last completed read value.
    logic [15:0] ref_mem [0:255];
    logic [15:0] model_rd = '0;

    typedef struct {
        bit          is_rd;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  sel;
        logic [15:0] exp_rd;
        int          e0;
    } txn_t;

    txn_t sbq[$];

    function automatic txn_t make_txn(input bit rd, input logic [19:0] a, input logic [15:0] d,
                                      input logic [1:0] s, input int e0);
        txn_t t;
        t.is_rd = rd; t.addr = a; t.wdata = d; t.sel = s; t.e0 = e0;
        if (rd) begin
            t.exp_rd = ref_mem[a[7:0]];
            model_rd = t.exp_rd;
        end else begin
            ref_mem[a[7:0]] = merge(ref_mem[a[7:0]], d, s);
            t.exp_rd = model_rd;
        end
        return t;
    endfunction

    // Monitor: per-access strobe tallies, compared when Done appears.
    int acc_n = 0, oe_n = 0, we_n = 0, doe_n = 0, stab_bad = 0, ul_bad = 0;
    bit prev_done = 1'b0;

    always @(negedge Clk) begin
        txn_t t;
        if (!Reset) begin
            acc_n = 0; oe_n = 0; we_n = 0; doe_n = 0; stab_bad = 0; ul_bad = 0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("busy_after_done", {31'd0, Busy}, 32'd0);
            prev_done = Done;
            if (!CE) begin
                acc_n++;
                if (!OE) oe_n++;
                if (!WE) we_n++;
                if (Data_OE) doe_n++;
                if (sbq.size() > 0) begin
                    if (SRAM_ADDR !== sbq[0].addr) stab_bad++;
                    if (!sbq[0].is_rd && SRAM_Dout !== sbq[0].wdata) stab_bad++;
                    if ({UB, LB} !== strobe_ul(sbq[0].sel)) ul_bad++;
                end
            end
            if (Done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    t = sbq.pop_front();
                    check("done_latency", cyc, t.e0 + W + 1);
                    check("rd_data", {16'd0, Rd_Data}, {16'd0, t.exp_rd});
                    check("access_cycles", acc_n, W + 1);
                    check("oe_low_cycles", oe_n, t.is_rd ? W + 1 : 0);
                    check("we_low_cycles", we_n, t.is_rd ? 0 : W);
                    check("data_oe_cycles", doe_n, t.is_rd ? 0 : W + 1);
                    check("addr_dout_stable", stab_bad, 0);
                    check("ub_lb", ul_bad, 0);
                    check("done_strobes", {25'd0, CE, OE, WE, UB, LB, Data_OE, Busy}, 32'b1111101);
                    if (!t.is_rd)
                        check("mem_word", {16'd0, mem[t.addr[7:0]]}, {16'd0, ref_mem[t.addr[7:0]]});
                end
                acc_n = 0; oe_n = 0; we_n = 0; doe_n = 0; stab_bad = 0; ul_bad = 0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (Busy !== 1'b0 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [19:0] a,
                         input logic [15:0] d, input logic [1:0] s);
        wait_idle();
        Req_Rd = rd; Req_Wr = wr; Addr = a; Wr_Data = d; Byte_Sel = s;
        if (rd || wr) sbq.push_back(make_txn(rd, a, d, s, cyc + 1));
        @(negedge Clk);
        Req_Rd = 1'b0; Req_Wr = 1'b0;
        Addr = 20'($urandom); Wr_Data = 16'($urandom); Byte_Sel = 2'($urandom);
    endtask

    initial begin
        int e0;
        int r;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        // Reset held with a pending read request.
        Reset = 1'b0; Req_Rd = 1'b1; Addr = 20'h00012;
        repeat (3) @(negedge Clk);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_strobes", {26'd0, CE, OE, WE, UB, LB, Data_OE}, 32'b111110);
        check("rst_rd_data", {16'd0, Rd_Data}, 32'd0);
        check("rst_addr_dout", {12'd0, SRAM_ADDR} | {16'd0, SRAM_Dout}, 32'd0);
        Req_Rd = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);

        issue(1, 0, 20'h00012, 16'h0000, 2'b11);
        issue(0, 1, 20'h00034, 16'h1234, 2'b11);
        issue(1, 1, 20'h00056, 16'hFFFF, 2'b11);
        wait_idle();
        check("rw_no_write", {16'd0, mem[8'h56]}, {16'd0, init_word(8'h56)});

        // Req_Rd held high: back-to-back reads every W+3 cycles.
        Req_Rd = 1'b1; Addr = 20'h00034; Byte_Sel = 2'b11;
        e0 = cyc + 1;
        for (int k = 0; k < 3; k++) sbq.push_back(make_txn(1, 20'h00034, 16'h0, 2'b11, e0 + k * (W + 3)));
        while (cyc < e0 + 3 * (W + 3) - 1) @(negedge Clk);
        Req_Rd = 1'b0;

        // Reset during the second ACCESS cycle of a read: no Done, then normal operation.
        wait_idle();
        Req_Rd = 1'b1; Addr = 20'h00099;
        e0 = cyc + 1;
        @(negedge Clk);
        Req_Rd = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("abort_strobes", {26'd0, CE, OE, WE, UB, LB, Data_OE}, 32'b111110);
        check("abort_busy_done", {30'd0, Busy, Done}, 32'd0);
        check("abort_rd_data", {16'd0, Rd_Data}, 32'd0);
        model_rd = '0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        issue(1, 0, 20'h00012, 16'h0, 2'b11);

`ifdef SRAM_SEQ_BYTE_EN
        issue(0, 1, 20'h00078, 16'hAB00, 2'b10);
        issue(1, 0, 20'h00078, 16'h0, 2'b11);
        issue(0, 1, 20'h00012, 16'h7777, 2'b00);
`endif

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 3);
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            issue(r == 0 || r == 2, r != 0, {12'($urandom), 8'($urandom)},
                  16'($urandom), 2'($urandom));
        end

        wait_idle();
        repeat (3) @(negedge Clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
